brch_target_buf_npc: RTL and testbench
======================================

Name: brch_target_buf_npc

Overview:
- Fetch-side next-PC unit with a direct-mapped branch target buffer (BTB).
- Consumes the gshare direction prediction in IF, looks up the predicted target and selects the next PC.
- Carries the prediction to ID, checks it against the resolved branch outcome, and issues redirect and flush on a mispredict.
- Also exports the low PC bits that index the direction predictor, and keeps saturating performance counters.

Parameters:
- PC_W, 32, PC and target width in bits.
- IDX_W, 4, BTB index width; the BTB has 2**IDX_W entries.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pc_if  in  PC_W  PC of the instruction in IF
- brch_instr_detectd_IF  in  1  IF instruction is a branch
- predict_br_taken  in  1  gshare taken prediction for the IF branch
- stall_if  in  1  IF/ID pipeline register hold
- brch_instr_detectd_ID  in  1  ID instruction is a branch
- brch_hazard_stall  in  1  ID branch operands are not ready
- actual_brch_result  in  1  resolved direction in ID
- brch_target_id  in  PC_W  computed branch target in ID
- branch_addr_lw_5b  out  5  pc_if[6:2], the direction predictor index
- btb_hit  out  1  valid BTB hit for the IF branch
- pc_next  out  PC_W  next fetch PC
- mispredict  out  1  single-cycle redirect pulse
- flush_if_id  out  1  squash the wrong-path IF instruction
- mispred_cnt  out  CNT_W  saturating mispredict count
- resolve_cnt  out  CNT_W  saturating resolved-branch count

Behaviour:
BTB structure and lookup
- Each entry holds {valid, tag = pc[PC_W-1:IDX_W+2], target}.
- Index is pc_if[IDX_W+1:2].
- Lookup is combinational: btb_hit = brch_instr_detectd_IF & valid & tag match.
- pred_taken_if = predict_br_taken & btb_hit.

Next-PC select, priority order
- mispredict active: redirect PC.
- pred_taken_if: BTB target.
- otherwise: pc_if+4.
- All adds are modulo 2**PC_W; wrap-around is allowed.

Prediction pipe register (IF to ID)
- Fields: {pend, pc, pred_taken, pred_target}.
- Acts as a two-state FSM: IDLE (pend=0) and PENDING (pend=1).
- Loaded when !stall_if; pend takes the value of brch_instr_detectd_IF.
- Held unchanged when stall_if=1.
- Cleared to IDLE when mispredict=1; flush takes priority over both stall and load.

Resolution
- Resolve condition: brch_instr_detectd_ID & !brch_hazard_stall & pend.
- While brch_hazard_stall=1 there is no resolve and no BTB write; the prediction stays PENDING.
- Mispredict cases, with redirect PC:
  - Actual taken, predicted not taken: redirect = brch_target_id.
  - Actual not taken, predicted taken: redirect = pipe.pc+4.
  - Both taken, pred_target != brch_target_id: redirect = brch_target_id.
- mispredict and flush_if_id are combinational, asserted only in the resolve cycle, and equal to each other.

BTB update
- Write on resolve with actual taken: valid=1, tag and target from pipe.pc and brch_target_id.
- Resolve with actual not taken does not touch the entry.
- A same-cycle lookup and write to the same index: the lookup returns the old contents.

Counters
- resolve_cnt increments on every resolve; mispred_cnt increments on every mispredict.
- Both saturate at all-ones.

Reset (rst_n=0 at a clock edge)
- All BTB valid bits clear, pipe register returns to IDLE, counters go to 0.
- mispredict=0, flush_if_id=0, and pc_next=pc_if+4 after reset.
- Reset mid-resolve discards the pending prediction and the BTB write.

Latency
- Lookup is 0 cycles.
- Resolve happens one cycle after IF when there are no stalls.
- The BTB write is visible to a lookup in the next cycle.

Decomposition:
- brch_pkg holds the PC_W, IDX_W and CNT_W defaults, the btb_entry_t struct {valid, tag, target}, and pred_pipe_t {pend, pc, pred_taken, pred_target}.
- One sub-module: btb_regs, the register-array storage with asynchronous read, synchronous write and synchronous valid clear.
- Next-PC select, the pipe register and the counters live in the top module.

Test Plan:
- Cold BTB: branch at 0x0000_0040, predict_br_taken=1. Required: btb_hit=0, pc_next=0x44. Then in ID, actual=1 with target 0x100. Required: mispredict=1, pc_next=0x100, BTB entry 0 written.
- Refetch 0x40 with predict_br_taken=1. Required: btb_hit=1, pc_next=0x100. Then actual=1, target 0x100. Required: mispredict=0, resolve_cnt=2, mispred_cnt=1.
- Refetch 0x40 predicted taken, actual=0. Required: mispredict=1, pc_next=0x44, flush_if_id=1, BTB entry unchanged.
- Alias: 0x80 (same index 0, different tag) gives btb_hit=0. Predicted taken with target mismatch (0x100 vs 0x200) gives a redirect to 0x200.
- brch_hazard_stall=1 for 2 cycles with stall_if=1. Required: no mispredict, pipe held, resolve in cycle 3 with the correct redirect.
- Drive 65 540 mispredicts. Required: mispred_cnt stuck at 0xFFFF. Assert rst_n=0 mid-resolve. Required: counters 0, btb_hit=0 on the next lookup.

Source files
------------

// File: rtl/brch_pkg.sv
// Shared widths and record types for the BTB next-PC unit.
// The structs are sized from the DEF_* widths, so they match the top at its default parameters.
package brch_pkg;

   localparam int DEF_PC_W  = 32;
   localparam int DEF_IDX_W = 4;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_TAG_W = DEF_PC_W - DEF_IDX_W - 2;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } pipe_state_t;

   typedef struct packed {
      logic                 valid;
      logic [DEF_TAG_W-1:0] tag;
      logic [DEF_PC_W-1:0]  target;
   } btb_entry_t;

   // The pend field is the IF->ID prediction FSM state.
   typedef struct packed {
      pipe_state_t         pend;
      logic [DEF_PC_W-1:0] pc;
      logic                pred_taken;
      logic [DEF_PC_W-1:0] pred_target;
   } pred_pipe_t;

endpackage

// File: rtl/brch_target_buf_npc_btb_regs.sv
// Direct-mapped BTB storage with asynchronous read and synchronous write.
// Reset clears only the valid bits; a read at the index being written returns the old entry.
module btb_regs
   import brch_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output btb_entry_t       rd_entry,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  btb_entry_t       wr_entry
);

   localparam int DEPTH = 1 << IDX_W;

   btb_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i].valid <= 1'b0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_entry;
      end
   end

   assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/brch_target_buf_npc.sv
// Fetch next-PC select with a direct-mapped BTB, an IF->ID prediction register,
// mispredict detection in ID, and saturating resolve/mispredict counters.
module brch_target_buf_npc
   import brch_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int IDX_W = DEF_IDX_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  pc_if,
   input  logic             brch_instr_detectd_IF,
   input  logic             predict_br_taken,
   input  logic             stall_if,
   input  logic             brch_instr_detectd_ID,
   input  logic             brch_hazard_stall,
   input  logic             actual_brch_result,
   input  logic [PC_W-1:0]  brch_target_id,
   output logic [4:0]       branch_addr_lw_5b,
   output logic             btb_hit,
   output logic [PC_W-1:0]  pc_next,
   output logic             mispredict,
   output logic             flush_if_id,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic [CNT_W-1:0] resolve_cnt
);

   btb_entry_t       rd_entry;
   btb_entry_t       wr_entry;
   pred_pipe_t       pipe;
   logic             pred_taken_if;
   logic             resolve;
   logic             btb_wr_en;
   logic [PC_W-1:0]  redirect_pc;
   logic [PC_W-1:0]  pipe_pc_plus4;

   assign branch_addr_lw_5b = pc_if[6:2];

   btb_regs #(.IDX_W(IDX_W)) u_btb_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (pc_if[IDX_W+1:2]),
      .rd_entry (rd_entry),
      .wr_en    (btb_wr_en),
      .wr_idx   (pipe.pc[IDX_W+1:2]),
      .wr_entry (wr_entry)
   );

   assign btb_hit       = brch_instr_detectd_IF & rd_entry.valid
                          & (rd_entry.tag == pc_if[PC_W-1:IDX_W+2]);
   assign pred_taken_if = predict_br_taken & btb_hit;

   // Gated by rst_n so a branch sitting in ID during reset neither redirects nor trains the BTB.
   assign resolve       = rst_n & brch_instr_detectd_ID & !brch_hazard_stall
                          & (pipe.pend == PENDING);
   assign pipe_pc_plus4 = pipe.pc + PC_W'(4);

   always_comb begin
      mispredict  = 1'b0;
      redirect_pc = pipe_pc_plus4;
      if (resolve) begin
         if (actual_brch_result && !pipe.pred_taken) begin
            mispredict  = 1'b1;
            redirect_pc = brch_target_id;
         end else if (!actual_brch_result && pipe.pred_taken) begin
            mispredict  = 1'b1;
            redirect_pc = pipe_pc_plus4;
         end else if (actual_brch_result && (pipe.pred_target != brch_target_id)) begin
            mispredict  = 1'b1;
            redirect_pc = brch_target_id;
         end
      end
   end

   assign flush_if_id = mispredict;

   always_comb begin
      if (mispredict) begin
         pc_next = redirect_pc;
      end else if (pred_taken_if) begin
         pc_next = rd_entry.target;
      end else begin
         pc_next = pc_if + PC_W'(4);
      end
   end

   assign btb_wr_en = resolve & actual_brch_result;
   assign wr_entry  = '{valid:  1'b1,
                        tag:    pipe.pc[PC_W-1:IDX_W+2],
                        target: brch_target_id};

   // Flush beats both hold and load: the wrong-path IF instruction must not become PENDING.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe <= '0;
      end else if (mispredict) begin
         pipe <= '0;
      end else if (!stall_if) begin
         pipe <= '{pend:        brch_instr_detectd_IF ? PENDING : IDLE,
                   pc:          pc_if,
                   pred_taken:  pred_taken_if,
                   pred_target: rd_entry.target};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resolve_cnt <= '0;
         mispred_cnt <= '0;
      end else begin
         if (resolve && (resolve_cnt != '1)) begin
            resolve_cnt <= resolve_cnt + CNT_W'(1);
         end
         if (mispredict && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_brch_target_buf_npc.sv
// Directed bench for brch_target_buf_npc: BTB training, aliasing, hazard hold,
// counter saturation and reset in the middle of a resolve.
module tb_brch_target_buf_npc;

   localparam int PC_W  = 32;
   localparam int IDX_W = 4;
   // Counters narrowed to 8 bits so saturation is reachable in a few hundred cycles.
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [PC_W-1:0]  pc_if;
   logic             brch_instr_detectd_IF;
   logic             predict_br_taken;
   logic             stall_if;
   logic             brch_instr_detectd_ID;
   logic             brch_hazard_stall;
   logic             actual_brch_result;
   logic [PC_W-1:0]  brch_target_id;
   logic [4:0]       branch_addr_lw_5b;
   logic             btb_hit;
   logic [PC_W-1:0]  pc_next;
   logic             mispredict;
   logic             flush_if_id;
   logic [CNT_W-1:0] mispred_cnt;
   logic [CNT_W-1:0] resolve_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] exp_mis;

   brch_target_buf_npc #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .pc_if                 (pc_if),
      .brch_instr_detectd_IF (brch_instr_detectd_IF),
      .predict_br_taken      (predict_br_taken),
      .stall_if              (stall_if),
      .brch_instr_detectd_ID (brch_instr_detectd_ID),
      .brch_hazard_stall     (brch_hazard_stall),
      .actual_brch_result    (actual_brch_result),
      .brch_target_id        (brch_target_id),
      .branch_addr_lw_5b     (branch_addr_lw_5b),
      .btb_hit               (btb_hit),
      .pc_next               (pc_next),
      .mispredict            (mispredict),
      .flush_if_id           (flush_if_id),
      .mispred_cnt           (mispred_cnt),
      .resolve_cnt           (resolve_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // driver tasks: called right after a negedge, outputs checked 1ns later
   task automatic drv_if(input logic [31:0] pc, input logic br, input logic pred, input logic stall);
      pc_if                 = pc;
      brch_instr_detectd_IF = br;
      predict_br_taken      = pred;
      stall_if              = stall;
   endtask

   task automatic drv_id(input logic br, input logic haz, input logic act, input logic [31:0] tgt);
      brch_instr_detectd_ID = br;
      brch_hazard_stall     = haz;
      actual_brch_result    = act;
      brch_target_id        = tgt;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drv_if(32'h0, 1'b0, 1'b0, 1'b0);
      drv_id(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);

      // after reset
      cyc(); rst_n = 1'b1; drv_if(32'h10, 1'b0, 1'b0, 1'b0); #1;
      chk("rst_pc_next", pc_next, 32'h14);
      chk("rst_mispredict", 32'(mispredict), 32'h0);
      chk("rst_flush", 32'(flush_if_id), 32'h0);
      chk("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
      chk("rst_resolve_cnt", 32'(resolve_cnt), 32'h0);

      // A: cold BTB lookup of 0x40
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); #1;
      chk("cold_hit", 32'(btb_hit), 32'h0);
      chk("cold_pc_next", pc_next, 32'h44);
      chk("bp_index", 32'(branch_addr_lw_5b), 32'h10);

      // B: resolve taken to 0x100; same-cycle lookup at index 0 still sees the old (invalid) entry
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h100); #1;
      chk("b_mispredict", 32'(mispredict), 32'h1);
      chk("b_flush", 32'(flush_if_id), 32'h1);
      chk("b_pc_next", pc_next, 32'h100);
      chk("b_same_cycle_hit", 32'(btb_hit), 32'h0);

      // C: refetch 0x40, now a hit
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("c_hit", 32'(btb_hit), 32'h1);
      chk("c_pc_next", pc_next, 32'h100);

      // D: correctly predicted taken
      cyc(); drv_if(32'h100, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h100); #1;
      chk("d_mispredict", 32'(mispredict), 32'h0);
      chk("d_pc_next", pc_next, 32'h104);

      // E: refetch 0x40 predicted taken
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("e_resolve_cnt", 32'(resolve_cnt), 32'h2);
      chk("e_mispred_cnt", 32'(mispred_cnt), 32'h1);
      chk("e_hit", 32'(btb_hit), 32'h1);

      // F: actually not taken -> fall through to 0x44
      cyc(); drv_if(32'h100, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b0, 32'h100); #1;
      chk("f_mispredict", 32'(mispredict), 32'h1);
      chk("f_flush", 32'(flush_if_id), 32'h1);
      chk("f_pc_next", pc_next, 32'h44);

      // G: entry untouched by the not-taken resolve
      cyc(); drv_if(32'h40, 1'b1, 1'b0, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("g_hit", 32'(btb_hit), 32'h1);
      chk("g_pc_next", pc_next, 32'h44);
      chk("g_resolve_cnt", 32'(resolve_cnt), 32'h3);
      chk("g_mispred_cnt", 32'(mispred_cnt), 32'h2);

      // H: alias 0x80 shares index 0 with a different tag
      cyc(); drv_if(32'h80, 1'b1, 1'b1, 1'b0); #1;
      chk("alias_hit", 32'(btb_hit), 32'h0);
      chk("alias_pc_next", pc_next, 32'h84);

      // I/J: predicted taken to 0x100, actual target 0x200
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); #1;
      chk("i_pc_next", pc_next, 32'h100);
      cyc(); drv_if(32'h100, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h200); #1;
      chk("tgt_mismatch_mispredict", 32'(mispredict), 32'h1);
      chk("tgt_mismatch_pc_next", pc_next, 32'h200);

      // K: updated target visible on the next lookup
      cyc(); drv_if(32'h40, 1'b1, 1'b1, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("k_pc_next", pc_next, 32'h200);

      // L/M: operand hazard with IF held for two cycles
      for (int i = 0; i < 2; i++) begin
         cyc(); drv_if(32'h204, 1'b0, 1'b0, 1'b1); drv_id(1'b1, 1'b1, 1'b1, 32'h300); #1;
         chk("haz_mispredict", 32'(mispredict), 32'h0);
         chk("haz_pc_next", pc_next, 32'h208);
      end

      // N: hazard clears; held prediction (target 0x200) resolves against 0x300
      cyc(); drv_if(32'h204, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h300); #1;
      chk("haz_resolve_mispredict", 32'(mispredict), 32'h1);
      chk("haz_resolve_pc_next", pc_next, 32'h300);

      cyc(); drv_if(32'h300, 1'b0, 1'b0, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("n_resolve_cnt", 32'(resolve_cnt), 32'h5);
      chk("n_mispred_cnt", 32'(mispred_cnt), 32'h4);

      // counter saturation: one taken-but-predicted-not-taken branch per two cycles
      exp_mis = 8'h4;
      for (int i = 0; i < 260; i++) begin
         cyc(); drv_if(32'h1000, 1'b1, 1'b0, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
         if (exp_q.size() != 0) chk("sat_mispred_cnt", 32'(mispred_cnt), 32'(exp_q.pop_front()));
         cyc(); drv_if(32'h2000, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h3000); #1;
         if (i == 255) chk("sat_mispredict_pulse", 32'(mispredict), 32'h1);
         exp_mis = (exp_mis == CNT_MAX) ? CNT_MAX : exp_mis + 8'h1;
         exp_q.push_back(exp_mis);
      end
      cyc(); drv_if(32'h2000, 1'b0, 1'b0, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("sat_mispred_final", 32'(mispred_cnt), 32'(exp_q.pop_front()));
      chk("sat_mispred_max", 32'(mispred_cnt), 32'(CNT_MAX));
      chk("sat_resolve_max", 32'(resolve_cnt), 32'(CNT_MAX));

      // reset asserted while a prediction is resolving
      cyc(); drv_if(32'h40, 1'b1, 1'b0, 1'b0); #1;
      cyc(); rst_n = 1'b0; drv_if(32'h44, 1'b0, 1'b0, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h500);
      cyc(); rst_n = 1'b1; drv_if(32'h40, 1'b1, 1'b1, 1'b0); drv_id(1'b1, 1'b0, 1'b1, 32'h600); #1;
      chk("post_rst_hit", 32'(btb_hit), 32'h0);
      chk("post_rst_pc_next", pc_next, 32'h44);
      chk("post_rst_mispredict", 32'(mispredict), 32'h0);
      chk("post_rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
      chk("post_rst_resolve_cnt", 32'(resolve_cnt), 32'h0);
      cyc(); drv_if(32'h1000, 1'b1, 1'b1, 1'b0); drv_id(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("post_rst_cnt_hold", 32'(resolve_cnt), 32'h0);
      chk("post_rst_hit_other", 32'(btb_hit), 32'h0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
